corevx_brcond_pipe: RTL and testbench
=====================================

Name: corevx_brcond_pipe

Overview:
Parametrised, pipelined branch-resolution unit for the corevx execute stage. Per branch it evaluates the RV32/RV64 branch condition selected by funct3, computes the target pc+imm, and flags illegal funct3 and misaligned taken targets. Results pass through 1 or 2 register stages with a valid/ready handshake, a synchronous flush input, and a saturating taken-branch counter for the perf block.

Parameters:
XLEN, 32, operand/pc width; legal values 32 or 64.
LATENCY, 1, number of pipeline register stages; legal values 1 or 2.
SUPPORT_C, 0, 1 means targets need only 2-byte alignment; 0 means 4-byte alignment.
CNT_W, 16, width of the taken-branch counter.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous reset, active low.
flush  in  1  synchronous kill of all in-flight entries.
in_valid  in  1  input beat valid.
in_ready  out  1  unit accepts a beat this cycle.
in_funct3  in  3  branch funct3.
in_rs1  in  XLEN  operand 1.
in_rs2  in  XLEN  operand 2.
in_pc  in  XLEN  branch instruction pc.
in_imm  in  XLEN  sign-extended B-immediate.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts the result.
out_taken  out  1  branch taken.
out_target  out  XLEN  pc+imm.
out_illegal  out  1  funct3 is 010 or 011.
out_misaligned  out  1  taken and target misaligned.
taken_count  out  CNT_W  saturating count of taken branches delivered.
cnt_clear  in  1  synchronous clear of taken_count.

Behaviour:
- Reset (rst_n low, async): all stage valid bits 0, out_valid 0, out_taken/out_illegal/out_misaligned 0, out_target 0, taken_count 0. in_ready is 1 from the first cycle after reset release.
- Conditions: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge, all over full XLEN. 010/011: taken=0, illegal=1, misaligned=0.
- Target: (in_pc + in_imm) mod 2^XLEN; wrap-around is silent. Target is always computed, including for not-taken and illegal beats.
- Misaligned: taken && target[1] when SUPPORT_C=0; taken && target[0] when SUPPORT_C=1. A not-taken branch never reports misaligned.
- Stage 1 registers the comparison and the target. With LATENCY=2, stage 2 registers the final outputs. Latency from accept to out_valid is exactly LATENCY cycles with no stalls.
- Handshake: a beat transfers when valid&&ready. Each stage loads when it is empty or its downstream transfers. in_ready = !stage1_valid || stage1_advances, so sustained throughput is one beat per cycle.
- Stall: while out_valid && !out_ready, all out_* outputs hold stable and the stages fill. No beat may be dropped or duplicated.
- in_ready never depends combinationally on in_valid. It may depend combinationally on out_ready.
- flush: at the next edge all valid bits clear. A beat presented in the flush cycle is discarded even if in_ready=1. A flush also suppresses any out transfer in that cycle from counting.
- taken_count increments by 1 per transfer with out_taken=1 and !out_illegal, and saturates at all-ones. cnt_clear zeroes it; if cnt_clear and an increment coincide, the result is 0.
- Reset mid-stall: everything clears immediately, and pending results are lost.

Test Plan:
- LATENCY=1, XLEN=32: funct3=100, rs1=0xFFFFFFFF, rs2=0x00000001 -> taken=1; funct3=110 with the same operands -> taken=0; out_valid exactly 1 cycle after accept.
- pc=0xFFFFFFF0, imm=0x00000020, funct3=000, rs1=rs2 -> target=0x00000010, taken=1, misaligned=0. pc=0x100, imm=0x2, SUPPORT_C=0 -> misaligned=1. Same with SUPPORT_C=1 -> misaligned=0. Same with rs1!=rs2 -> misaligned=0.
- funct3=010 -> illegal=1, taken=0, and taken_count is unchanged.
- LATENCY=2: stream 8 back-to-back beats with out_ready toggling 1,0,0,1,...: all 8 results appear in order, outputs are stable while stalled, and in_ready drops only when both stages are full.
- flush asserted while 2 beats are in flight and in_valid=1 -> out_valid=0 next cycle, and none of the 3 beats ever appears.
- CNT_W=2: deliver 5 taken branches -> taken_count saturates at 3. cnt_clear coincident with a taken transfer -> 0. Async rst_n pulse mid-stall -> all outputs 0 immediately.

Source files
------------

// File: rtl/corevx_brcond_pipe.sv
// Branch-resolution unit: evaluates the funct3 branch condition and pc+imm target,
// then carries the result through LATENCY register stages under a valid/ready handshake.
module corevx_brcond_pipe #(
    parameter int XLEN      = 32,
    parameter int LATENCY   = 1,
    parameter int SUPPORT_C = 0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic [XLEN-1:0]  out_target,
    output logic             out_illegal,
    output logic             out_misaligned,
    output logic [CNT_W-1:0] taken_count,
    input  logic             cnt_clear
);

    logic            w_cond_taken;
    logic            w_cond_illegal;
    logic [XLEN-1:0] w_target;
    logic            w_misaligned;
    logic            w_s1_adv;
    logic            w_out_xfer;
    logic            w_cnt_inc;

    logic            r_s1_valid;
    logic            r_s1_taken;
    logic            r_s1_illegal;
    logic            r_s1_mis;
    logic [XLEN-1:0] r_s1_target;
    logic [CNT_W-1:0] r_taken_count;

    always_comb begin
        w_cond_taken   = 1'b0;
        w_cond_illegal = 1'b0;
        case (in_funct3)
            3'b000:  w_cond_taken = (in_rs1 == in_rs2);
            3'b001:  w_cond_taken = (in_rs1 != in_rs2);
            3'b100:  w_cond_taken = ($signed(in_rs1) <  $signed(in_rs2));
            3'b101:  w_cond_taken = ($signed(in_rs1) >= $signed(in_rs2));
            3'b110:  w_cond_taken = (in_rs1 <  in_rs2);
            3'b111:  w_cond_taken = (in_rs1 >= in_rs2);
            default: w_cond_illegal = 1'b1;
        endcase
    end

    assign w_target     = in_pc + in_imm;
    // Compressed support relaxes the alignment requirement from 4 to 2 bytes.
    assign w_misaligned = w_cond_taken && ((SUPPORT_C != 0) ? w_target[0] : w_target[1]);

    assign in_ready   = !r_s1_valid || w_s1_adv;
    assign w_out_xfer = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_taken   <= 1'b0;
            r_s1_illegal <= 1'b0;
            r_s1_mis     <= 1'b0;
            r_s1_target  <= '0;
        end else begin
            if (flush) begin
                r_s1_valid <= 1'b0;
            end else if (in_ready) begin
                r_s1_valid <= in_valid;
            end
            if (in_valid && in_ready) begin
                r_s1_taken   <= w_cond_taken;
                r_s1_illegal <= w_cond_illegal;
                r_s1_mis     <= w_misaligned;
                r_s1_target  <= w_target;
            end
        end
    end

    generate
        if (LATENCY == 2) begin : g_two_stage
            logic            r_s2_valid;
            logic            r_s2_taken;
            logic            r_s2_illegal;
            logic            r_s2_mis;
            logic [XLEN-1:0] r_s2_target;
            logic            w_s2_load;

            assign w_s2_load = !r_s2_valid || w_out_xfer;
            assign w_s1_adv  = r_s1_valid && w_s2_load;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_s2_valid   <= 1'b0;
                    r_s2_taken   <= 1'b0;
                    r_s2_illegal <= 1'b0;
                    r_s2_mis     <= 1'b0;
                    r_s2_target  <= '0;
                end else begin
                    if (flush) begin
                        r_s2_valid <= 1'b0;
                    end else if (w_s2_load) begin
                        r_s2_valid <= r_s1_valid;
                    end
                    if (w_s2_load && r_s1_valid) begin
                        r_s2_taken   <= r_s1_taken;
                        r_s2_illegal <= r_s1_illegal;
                        r_s2_mis     <= r_s1_mis;
                        r_s2_target  <= r_s1_target;
                    end
                end
            end

            assign out_valid      = r_s2_valid;
            assign out_taken      = r_s2_taken;
            assign out_illegal    = r_s2_illegal;
            assign out_misaligned = r_s2_mis;
            assign out_target     = r_s2_target;
        end else begin : g_one_stage
            assign w_s1_adv       = w_out_xfer;
            assign out_valid      = r_s1_valid;
            assign out_taken      = r_s1_taken;
            assign out_illegal    = r_s1_illegal;
            assign out_misaligned = r_s1_mis;
            assign out_target     = r_s1_target;
        end
    endgenerate

    // A transfer killed by a coincident flush is not counted as delivered.
    assign w_cnt_inc = w_out_xfer && out_taken && !out_illegal && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_taken_count <= '0;
        end else if (cnt_clear) begin
            r_taken_count <= '0;
        end else if (w_cnt_inc && (r_taken_count != {CNT_W{1'b1}})) begin
            r_taken_count <= r_taken_count + 1'b1;
        end
    end

    assign taken_count = r_taken_count;

endmodule

// File: tb/tb_corevx_brcond_pipe.sv
// Scoreboard bench for corevx_brcond_pipe: instance 0 is XLEN=32/LATENCY=1/4-byte alignment,
// instance 1 is XLEN=64/LATENCY=2/2-byte alignment with a 2-bit counter.
module tb_corevx_brcond_pipe;

    typedef struct packed {
        logic        tk;
        logic        ill;
        logic        mis;
        logic [63:0] tgt;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  in_valid_v, out_ready_v, flush_v, clr_v;
    wire  [1:0]  in_ready_v, out_valid_v, taken_v, ill_v, mis_v;
    logic [2:0]  f3_a  [2];
    logic [63:0] rs1_a [2];
    logic [63:0] rs2_a [2];
    logic [63:0] pc_a  [2];
    logic [63:0] imm_a [2];
    wire  [31:0] tgt0;
    wire  [63:0] tgt1;
    wire  [15:0] cnt0;
    wire  [1:0]  cnt1;
    logic [63:0] tgt_a [2];
    logic [15:0] cnt_a [2];
    int          n_cmp = 0;
    int          n_err = 0;
    int          outstanding [2];

    assign tgt_a[0] = {32'b0, tgt0};
    assign tgt_a[1] = tgt1;
    assign cnt_a[0] = cnt0;
    assign cnt_a[1] = {14'b0, cnt1};

    corevx_brcond_pipe #(.XLEN(32), .LATENCY(1), .SUPPORT_C(0), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush_v[0]),
        .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]), .in_funct3(f3_a[0]),
        .in_rs1(rs1_a[0][31:0]), .in_rs2(rs2_a[0][31:0]), .in_pc(pc_a[0][31:0]), .in_imm(imm_a[0][31:0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .out_taken(taken_v[0]),
        .out_target(tgt0), .out_illegal(ill_v[0]), .out_misaligned(mis_v[0]),
        .taken_count(cnt0), .cnt_clear(clr_v[0])
    );

    corevx_brcond_pipe #(.XLEN(64), .LATENCY(2), .SUPPORT_C(1), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush_v[1]),
        .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]), .in_funct3(f3_a[1]),
        .in_rs1(rs1_a[1]), .in_rs2(rs2_a[1]), .in_pc(pc_a[1]), .in_imm(imm_a[1]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .out_taken(taken_v[1]),
        .out_target(tgt1), .out_illegal(ill_v[1]), .out_misaligned(mis_v[1]),
        .taken_count(cnt1), .cnt_clear(clr_v[1])
    );

    task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [63:0] xmask(int i);
        return (i == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    // Reference: branch rules evaluated on plain integers of the instance's width.
    function automatic exp_t model(int i, logic [2:0] f, logic [63:0] a_in, logic [63:0] b_in,
                                   logic [63:0] p, logic [63:0] m);
        exp_t        e;
        logic [63:0] a, b;
        longint      sa, sb;
        a = a_in & xmask(i);
        b = b_in & xmask(i);
        sa = (i == 0) ? longint'($signed(a[31:0])) : $signed(a);
        sb = (i == 0) ? longint'($signed(b[31:0])) : $signed(b);
        e.ill = 1'b0;
        e.tk  = 1'b0;
        case (f)
            3'd0: e.tk = (a == b);
            3'd1: e.tk = (a != b);
            3'd4: e.tk = (sa < sb);
            3'd5: e.tk = (sa >= sb);
            3'd6: e.tk = (a < b);
            3'd7: e.tk = (a >= b);
            default: e.ill = 1'b1;
        endcase
        e.tgt = (p + m) & xmask(i);
        e.mis = e.tk && ((i == 1) ? e.tgt[0] : e.tgt[1]);
        return e;
    endfunction

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_mon
            localparam int LAT  = (gi == 0) ? 1 : 2;
            localparam int CMAX = (gi == 0) ? 65535 : 3;
            exp_t q[$];
            exp_t prev, act, e;
            logic prev_stall;
            int   cnt_m;
            initial begin
                prev_stall = 1'b0;
                cnt_m = 0;
                outstanding[gi] = 0;
                forever begin
                    @(negedge clk);
                    if (!rst_n) begin
                        q.delete();
                        prev_stall = 1'b0;
                        cnt_m = 0;
                    end else begin
                        act = {taken_v[gi], ill_v[gi], mis_v[gi], tgt_a[gi]};
                        chk($sformatf("i%0d_in_ready", gi), in_ready_v[gi],
                            !(q.size() == LAT && !out_ready_v[gi]));
                        chk($sformatf("i%0d_taken_count", gi), cnt_a[gi], cnt_m);
                        if (q.size() == 0)
                            chk($sformatf("i%0d_valid_when_empty", gi), out_valid_v[gi], 0);
                        if (prev_stall) begin
                            chk($sformatf("i%0d_stall_valid", gi), out_valid_v[gi], 1);
                            chk($sformatf("i%0d_stall_flags", gi), {act.tk, act.ill, act.mis},
                                {prev.tk, prev.ill, prev.mis});
                            chk($sformatf("i%0d_stall_target", gi), act.tgt, prev.tgt);
                        end
                        if (out_valid_v[gi] && out_ready_v[gi] && !flush_v[gi] && q.size() > 0) begin
                            e = q.pop_front();
                            chk($sformatf("i%0d_taken", gi), act.tk, e.tk);
                            chk($sformatf("i%0d_illegal", gi), act.ill, e.ill);
                            chk($sformatf("i%0d_misaligned", gi), act.mis, e.mis);
                            chk($sformatf("i%0d_target", gi), act.tgt, e.tgt);
                            if (!clr_v[gi] && e.tk && !e.ill && cnt_m < CMAX) cnt_m++;
                        end
                        if (clr_v[gi]) cnt_m = 0;
                        if (in_valid_v[gi] && in_ready_v[gi] && !flush_v[gi])
                            q.push_back(model(gi, f3_a[gi], rs1_a[gi], rs2_a[gi], pc_a[gi], imm_a[gi]));
                        if (flush_v[gi]) q.delete();
                        prev_stall = out_valid_v[gi] && !out_ready_v[gi] && !flush_v[gi];
                        prev = act;
                    end
                    outstanding[gi] = q.size();
                end
            end
        end
    endgenerate

    task automatic drive(int i, logic [2:0] f, logic [63:0] a, logic [63:0] b, logic [63:0] p, logic [63:0] m);
        f3_a[i] = f; rs1_a[i] = a; rs2_a[i] = b; pc_a[i] = p; imm_a[i] = m;
    endtask

    task automatic send(int i, logic [2:0] f, logic [63:0] a, logic [63:0] b, logic [63:0] p, logic [63:0] m);
        int n = 0;
        @(posedge clk); #1;
        drive(i, f, a, b, p, m);
        in_valid_v[i] = 1'b1;
        @(negedge clk);
        while (!in_ready_v[i] && n < 200) begin @(negedge clk); n++; end
        chk($sformatf("i%0d_send_accept", i), in_ready_v[i], 1);
        @(posedge clk); #1 in_valid_v[i] = 1'b0;
    endtask

    task automatic send_lat(int i, logic [2:0] f, logic [63:0] a, logic [63:0] b, logic [63:0] p, logic [63:0] m);
        send(i, f, a, b, p, m);
        for (int k = 1; k <= i + 1; k++) begin
            @(negedge clk);
            chk($sformatf("i%0d_latency_c%0d", i, k), out_valid_v[i], (k == i + 1));
        end
    endtask

    task automatic stream(int i, int n, int toggle);
        int sent = 0;
        int cyc  = 0;
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [63:0] a;
        while (sent < n && cyc < 5000) begin
            @(posedge clk); #1;
            a = {$urandom, $urandom};
            drive(i, 3'($urandom_range(0, 7)), a,
                  ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom},
                  {$urandom, $urandom}, {$urandom, $urandom});
            in_valid_v[i]  = toggle ? 1'b1 : ($urandom_range(0, 3) != 0);
            out_ready_v[i] = toggle ? pat[cyc % 4] : ($urandom_range(0, 3) != 0);
            flush_v[i]     = toggle ? 1'b0 : ($urandom_range(0, 49) == 0);
            clr_v[i]       = toggle ? 1'b0 : ($urandom_range(0, 39) == 0);
            @(negedge clk);
            if (in_valid_v[i] && in_ready_v[i] && !flush_v[i]) sent++;
            cyc++;
        end
        chk($sformatf("i%0d_stream_budget", i), sent, n);
        @(posedge clk); #1;
        in_valid_v[i] = 1'b0; flush_v[i] = 1'b0; clr_v[i] = 1'b0; out_ready_v[i] = 1'b1;
        repeat (8) @(negedge clk);
        chk($sformatf("i%0d_drain", i), outstanding[i], 0);
    endtask

    task automatic chk_zero(int i, string tag);
        chk($sformatf("i%0d_%s_valid", i, tag), out_valid_v[i], 0);
        chk($sformatf("i%0d_%s_flags", i, tag), {taken_v[i], ill_v[i], mis_v[i]}, 0);
        chk($sformatf("i%0d_%s_target", i, tag), tgt_a[i], 0);
        chk($sformatf("i%0d_%s_count", i, tag), cnt_a[i], 0);
    endtask

    initial begin
        logic [63:0] mk;
        int          n;
        rst_n = 1'b0;
        in_valid_v = '0; out_ready_v = 2'b11; flush_v = '0; clr_v = '0;
        for (int i = 0; i < 2; i++) drive(i, 3'd0, 64'd0, 64'd0, 64'd0, 64'd0);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) chk_zero(i, "reset");
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) chk($sformatf("i%0d_ready_after_reset", i), in_ready_v[i], 1);

        for (int i = 0; i < 2; i++) begin
            mk = xmask(i);
            send_lat(i, 3'b100, mk, 64'd1, 64'h1000, 64'h8);
            send_lat(i, 3'b110, mk, 64'd1, 64'h1000, 64'h8);
            send_lat(i, 3'b000, 64'd5, 64'd5, mk - 64'hF, 64'h20);
            send_lat(i, 3'b000, 64'd7, 64'd7, 64'h100, 64'h2);
            send_lat(i, 3'b000, 64'd7, 64'd8, 64'h100, 64'h2);
            send_lat(i, 3'b010, 64'd3, 64'd3, 64'h104, 64'h4);
            send_lat(i, 3'b011, 64'd3, 64'd4, 64'h106, 64'h2);
        end

        for (int i = 0; i < 2; i++) begin
            stream(i, 300, 0);
            stream(i, 8, 1);
        end

        // Flush with two beats in flight and a third beat presented.
        @(posedge clk); #1 out_ready_v[1] = 1'b0;
        send(1, 3'b000, 64'd1, 64'd1, 64'h300, 64'h4);
        send(1, 3'b001, 64'd1, 64'd2, 64'h310, 64'h4);
        @(posedge clk); #1;
        drive(1, 3'b000, 64'd2, 64'd2, 64'h320, 64'h4);
        in_valid_v[1] = 1'b1; flush_v[1] = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        in_valid_v[1] = 1'b0; flush_v[1] = 1'b0; out_ready_v[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("i1_flush_empty_c%0d", k), out_valid_v[1], 0);
        end
        // Flush on an empty LATENCY=1 pipe while in_ready is high.
        @(posedge clk); #1;
        drive(0, 3'b000, 64'd2, 64'd2, 64'h320, 64'h4);
        in_valid_v[0] = 1'b1; flush_v[0] = 1'b1;
        @(negedge clk);
        chk("i0_flush_ready_high", in_ready_v[0], 1);
        @(posedge clk); #1 in_valid_v[0] = 1'b0; flush_v[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("i0_flush_empty_c%0d", k), out_valid_v[0], 0);
        end

        // Counter saturation on the 2-bit instance.
        @(posedge clk); #1 clr_v[1] = 1'b1;
        @(posedge clk); #1 clr_v[1] = 1'b0;
        repeat (5) send(1, 3'b000, 64'd9, 64'd9, 64'h200, 64'h10);
        repeat (3) @(negedge clk);
        chk("i1_count_saturated", cnt_a[1], 3);

        // Clear coincident with a taken transfer.
        @(posedge clk); #1 out_ready_v[1] = 1'b0;
        send(1, 3'b000, 64'd9, 64'd9, 64'h200, 64'h10);
        n = 0;
        @(negedge clk);
        while (!out_valid_v[1] && n < 20) begin @(negedge clk); n++; end
        chk("i1_wait_valid", out_valid_v[1], 1);
        @(posedge clk); #1 out_ready_v[1] = 1'b1; clr_v[1] = 1'b1;
        @(posedge clk); #1 out_ready_v[1] = 1'b0; clr_v[1] = 1'b0;
        @(negedge clk);
        chk("i1_clear_wins", cnt_a[1], 0);

        // Asynchronous reset while stalled.
        @(posedge clk); #1 out_ready_v[1] = 1'b1;
        send(1, 3'b000, 64'd9, 64'd9, 64'h200, 64'h10);
        repeat (3) @(negedge clk);
        chk("i1_count_before_reset", cnt_a[1], 1);
        @(posedge clk); #1 out_ready_v[1] = 1'b0;
        send(1, 3'b000, 64'd9, 64'd9, 64'h210, 64'h10);
        send(1, 3'b000, 64'd9, 64'd9, 64'h220, 64'h10);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) chk_zero(i, "async_reset");
        @(posedge clk); #2 rst_n = 1'b1; out_ready_v[1] = 1'b1;
        repeat (4) @(negedge clk);
        chk("i1_after_reset_valid", out_valid_v[1], 0);
        chk("i1_after_reset_outstanding", outstanding[1], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
